// File: rtl/abs_diff_arbiter.sv
// Round-robin arbiter feeding one shared 4-bit absolute-difference unit.
// A grant latches the operands; the result is held until the consumer accepts it.
module abs_diff_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [4*NREQ-1:0]    req_a,
    input  logic [4*NREQ-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    output logic [7:0]           rsp_diff,
    output logic [1:0]           rsp_id,
    input  logic                 rsp_ready,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] win_idx;
    logic       win_found;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [1:0] op_id;
    logic [3:0] valid_ext;
    logic [3:0] grant_ext;
    logic [15:0] a_ext;
    logic [15:0] b_ext;
    logic [1:0] cand;

    assign valid_ext = 4'(req_valid);
    assign a_ext     = 16'(req_a);
    assign b_ext     = 16'(req_b);

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = 2'((32'(ptr) + i) % NREQ);
            if (!win_found && valid_ext[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Grant is combinational so the transfer completes in the request cycle;
    // gated by rst_n so it is forced low while reset is held.
    always_comb begin
        grant_ext = '0;
        if (rst_n && state == IDLE && win_found)
            grant_ext[win_idx] = 1'b1;
    end

    assign req_ready = grant_ext[NREQ-1:0];
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_diff  <= '0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        op_a  <= a_ext[{win_idx, 2'b00} +: 4];
                        op_b  <= b_ext[{win_idx, 2'b00} +: 4];
                        op_id <= win_idx;
                        ptr   <= (win_idx == 2'(NREQ - 1)) ? 2'd0 : win_idx + 2'd1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rsp_diff  <= {4'b0000, (op_a > op_b) ? (op_a - op_b) : (op_b - op_a)};
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_abs_diff_arbiter.sv
// Self-checking bench for abs_diff_arbiter: directed scenarios plus random
// transactions checked against a round-robin / absolute-difference model.
module tb_abs_diff_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_diff;
    logic [1:0]  rsp_id;
    logic        rsp_ready = 1'b0;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int ptr_m = 0;

    abs_diff_arbiter #(.NREQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_diff(rsp_diff),
        .rsp_id(rsp_id), .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int model_pick(input logic [3:0] v);
        for (int k = 0; k < 4; k++)
            if (v[2'((ptr_m + k) % 4)]) return (ptr_m + k) % 4;
        return -1;
    endfunction

    function automatic int model_abs(input logic [3:0] a, input logic [3:0] b);
        int d;
        d = int'(a) - int'(b);
        return (d < 0) ? -d : d;
    endfunction

    function automatic logic [15:0] place(input int idx, input logic [3:0] val);
        logic [15:0] r;
        r = 16'($urandom);
        r[idx*4 +: 4] = val;
        return r;
    endfunction

    // Drives one transaction from IDLE and observes it; callers do the comparing.
    task automatic run_txn(input logic [3:0] valid, input logic [15:0] a, input logic [15:0] b,
                           input int hold, output logic [3:0] grant, output int lat,
                           output logic [7:0] diff, output logic [1:0] id);
        req_valid = valid; req_a = a; req_b = b; rsp_ready = 1'b0;
        #1 grant = req_ready;
        @(posedge clk); #1;
        req_valid = '0; req_a = 16'($urandom); req_b = 16'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        diff = rsp_diff; id = rsp_id;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic release_reset();
        req_valid = '0; rsp_ready = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        ptr_m = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'hF; req_a = 16'hFFFF; req_b = '0;
        #1;
        checks++;
        if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
            rsp_diff !== 8'd0 || rsp_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b valid=%b busy=%b diff=%0d id=%0d exp all zero",
                     req_ready, rsp_valid, busy, rsp_diff, rsp_id);
        end
        release_reset();
        checks++;
        if (busy !== 1'b0 || req_ready !== 4'b0) begin
            failures++;
            $display("FAIL reset_release_idle got busy=%b ready=%b exp 0/0000", busy, req_ready);
        end
    endtask

    task automatic test_single();
        logic [3:0] g; int lat; logic [7:0] d; logic [1:0] id;
        run_txn(4'b0010, place(1, 4'd9), place(1, 4'd3), 0, g, lat, d, id);
        ptr_m = 2;
        checks++;
        if (g !== 4'b0010) begin failures++; $display("FAIL single_grant got=%b exp=0010", g); end
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", lat); end
        checks++;
        if (d !== 8'd6 || id !== 2'd1) begin
            failures++; $display("FAIL single_result got diff=%0d id=%0d exp diff=6 id=1", d, id);
        end
    endtask

    task automatic test_values();
        int idx_t[3] = '{2, 3, 0};
        int a_t[3] = '{2, 7, 15};
        int b_t[3] = '{11, 7, 0};
        int exp_t[3] = '{9, 0, 15};
        logic [3:0] g; int lat; logic [7:0] d; logic [1:0] id;
        for (int k = 0; k < 3; k++) begin
            run_txn(4'(1 << idx_t[k]), place(idx_t[k], 4'(a_t[k])), place(idx_t[k], 4'(b_t[k])),
                    k, g, lat, d, id);
            ptr_m = (idx_t[k] + 1) % 4;
            checks++;
            if (d !== 8'(exp_t[k]) || id !== 2'(idx_t[k])) begin
                failures++;
                $display("FAIL values_%0d got diff=%0d id=%0d exp diff=%0d id=%0d",
                         k, d, id, exp_t[k], idx_t[k]);
            end
        end
    endtask

    task automatic test_operand_change();
        logic [3:0] g;
        req_valid = 4'b1000; req_a = place(3, 4'd12); req_b = place(3, 4'd5);
        #1 g = req_ready;
        @(posedge clk); #1;
        req_a = place(3, 4'd0); req_b = place(3, 4'd15); req_valid = '0;
        @(posedge clk); #1;
        ptr_m = 0;
        checks++;
        if (g !== 4'b1000 || rsp_valid !== 1'b1 || rsp_diff !== 8'd7 || rsp_id !== 2'd3) begin
            failures++;
            $display("FAIL operand_latch got ready=%b valid=%b diff=%0d id=%0d exp 1000/1/7/3",
                     g, rsp_valid, rsp_diff, rsp_id);
        end
        rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int w, w2, e;
        logic [3:0] a4, b4;
        a4 = 4'($urandom); b4 = 4'($urandom);
        w = model_pick(4'b1001);
        req_valid = 4'b1001; req_a = place(w, a4); req_b = place(w, b4);
        @(posedge clk); #1;
        ptr_m = (w + 1) % 4;
        e = model_abs(a4, b4);
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_diff !== 8'(e) || rsp_id !== 2'(w) ||
                req_ready !== 4'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL backpressure_c%0d got v=%b d=%0d id=%0d rdy=%b busy=%b exp 1/%0d/%0d/0000/1",
                         c, rsp_valid, rsp_diff, rsp_id, req_ready, busy, e, w);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        w2 = model_pick(4'b1001);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'(1 << w2)) begin
            failures++;
            $display("FAIL backpressure_release got busy=%b v=%b rdy=%b exp 0/0/%b",
                     busy, rsp_valid, req_ready, 4'(1 << w2));
        end
        req_valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_fairness();
        int g_idx[$], g_cyc[$], ids[$];
        rst_n = 1'b0; #2;
        release_reset();
        req_valid = 4'hF; rsp_ready = 1'b1; req_a = 16'($urandom); req_b = 16'($urandom);
        #1;
        for (int k = 0; k < 15; k++) begin
            if (req_ready != 4'b0) begin
                for (int i = 0; i < 4; i++) if (req_ready[i]) g_idx.push_back(i);
                g_cyc.push_back(k);
            end
            if (rsp_valid) ids.push_back(int'(rsp_id));
            @(posedge clk); #1;
        end
        req_valid = '0; rsp_ready = 1'b0;
        ptr_m = 1;
        checks++;
        if (g_idx.size() < 5 || ids.size() < 5) begin
            failures++;
            $display("FAIL fairness_count got grants=%0d rsps=%0d exp >=5", g_idx.size(), ids.size());
        end else begin
            for (int j = 0; j < 5; j++) begin
                checks++;
                if (g_idx[j] != j % 4 || ids[j] != j % 4 || (j > 0 && g_cyc[j] - g_cyc[j-1] != 3)) begin
                    failures++;
                    $display("FAIL fairness_%0d got grant=%0d id=%0d gap=%0d exp %0d/%0d/3",
                             j, g_idx[j], ids[j], (j > 0) ? g_cyc[j] - g_cyc[j-1] : 3, j % 4, j % 4);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        logic [3:0] g; int lat; logic [7:0] d; logic [1:0] id;
        bit seen;
        req_valid = 4'b0010; req_a = 16'($urandom); req_b = 16'($urandom);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1) begin failures++; $display("FAIL async_pre_hold got v=%b exp 1", rsp_valid); end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0 || rsp_diff !== 8'd0 || rsp_id !== 2'd0) begin
            failures++;
            $display("FAIL async_reset_now got v=%b busy=%b rdy=%b d=%0d id=%0d exp all zero",
                     rsp_valid, busy, req_ready, rsp_diff, rsp_id);
        end
        @(posedge clk);
        release_reset();
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            if (rsp_valid || busy) seen = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL async_no_response got activity=1 exp 0"); end
        run_txn(4'b1100, 16'($urandom), 16'($urandom), 0, g, lat, d, id);
        ptr_m = 3;
        checks++;
        if (g !== 4'b0100 || id !== 2'd2) begin
            failures++; $display("FAIL async_first_grant got rdy=%b id=%0d exp 0100/2", g, id);
        end
    endtask

    task automatic test_random();
        logic [3:0] g, v, a4, b4; int lat, w, e; logic [7:0] d; logic [1:0] id;
        logic [15:0] a, b;
        for (int n = 0; n < 40; n++) begin
            v = 4'($urandom_range(1, 15));
            a = 16'($urandom); b = 16'($urandom);
            w = model_pick(v);
            a4 = a[w*4 +: 4]; b4 = b[w*4 +: 4];
            e = model_abs(a4, b4);
            run_txn(v, a, b, int'($urandom_range(0, 3)), g, lat, d, id);
            ptr_m = (w + 1) % 4;
            checks++;
            if (g !== 4'(1 << w) || lat !== 2 || d !== 8'(e) || id !== 2'(w)) begin
                failures++;
                $display("FAIL random_%0d got rdy=%b lat=%0d d=%0d id=%0d exp rdy=%b lat=2 d=%0d id=%0d",
                         n, g, lat, d, id, 4'(1 << w), e, w);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_values();
        test_operand_change();
        test_backpressure();
        test_fairness();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
